// File: rtl/redbus_io_expander_multi_if.sv
// RedBus control/address bundle for redbus_io_expander_multi.
// Carries the address and the three level strobes. The 8-bit Data bus is a
// shared tristate pin and stays a plain inout on the device itself.
//   Address     : 16-bit RedBus address
//   ReadRedbus  : read strobe (level, sampled on the clock)
//   WriteRedbus : write strobe (level, sampled on the clock)
//   Enable      : device select
interface redbus_io_expander_multi_if;
  logic [15:0] Address;
  logic        ReadRedbus;
  logic        WriteRedbus;
  logic        Enable;

  modport master (output Address, output ReadRedbus, output WriteRedbus, output Enable);
  modport slave  (input  Address, input  ReadRedbus, input  WriteRedbus, input  Enable);
endinterface

// File: rtl/redbus_io_expander_multi.sv
// Multi-channel RedBus IO expander: CHANNELS x 16-bit open-collector ports.
// Each channel has synchronised inputs, an output latch, sticky write-1-to-clear
// change flags and an irq mask. Channel c lives at BASE_ADDR + 8*c + offset:
//   0/1 input lo/hi (ro), 2/3 output latch lo/hi, 4/5 change lo/hi (W1C), 6/7 mask lo/hi.
// Optional macro IOEXP_OUTPUT_READBACK_EN: offsets 2/3 read back the output
// latch; otherwise they read 8'h00.
// Ports:
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : RedBus address/strobes (slave modport)
//   Data         : 8-bit RedBus data, driven only during a hitting read
//   IOPort       : 16*CHANNELS open-collector pins (1 or Z)
//   Irq          : registered OR of change & mask over all channels

// One 16-bit channel: sync chain, change detect, latch/mask registers.
module redbus_io_expander_multi_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,     // qualified write edge for this channel
  input  logic [2:0]  off_i,
  input  logic [7:0]  wdata_i,
  input  logic [15:0] pin_i,
  output logic [15:0] in_o,
  output logic [15:0] out_o,
  output logic [15:0] chg_o,
  output logic [15:0] mask_o
);
  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0] last_q, out_q, out_d, chg_q, chg_d, mask_q, mask_d;
  logic [15:0] bsel, wide, clr, set;

  always_comb begin
    bsel   = off_i[0] ? 16'hFF00 : 16'h00FF;
    wide   = {wdata_i, wdata_i};
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_i) begin
      case (off_i[2:1])
        2'd1:    out_d  = (out_q & ~bsel) | (wide & bsel);
        2'd2:    clr    = wide & bsel;
        2'd3:    mask_d = (mask_q & ~bsel) | (wide & bsel);
        default: ;  // input registers are read-only
      endcase
    end
    // any edge on the synchronised pin; set wins over a same-cycle clear
    set   = sync_q[SYNC_STAGES-1] ^ last_q;
    chg_d = (chg_q & ~clr) | set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= '0;
      out_q  <= '0;
      chg_q  <= '0;
      mask_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      last_q <= sync_q[SYNC_STAGES-1];
      out_q  <= out_d;
      chg_q  <= chg_d;
      mask_q <= mask_d;
    end
  end

  assign in_o   = sync_q[SYNC_STAGES-1];
  assign out_o  = out_q;
  assign chg_o  = chg_q;
  assign mask_o = mask_q;
endmodule

module redbus_io_expander_multi #(
  parameter int          CHANNELS    = 1,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  redbus_io_expander_multi_if.slave  bus,
  inout  wire  [7:0]                 Data,
  inout  wire  [16*CHANNELS-1:0]     IOPort,
  output logic                       Irq
);
  logic [CHANNELS-1:0][15:0] in_w, out_w, chg_w, mask_w;
  logic [16*CHANNELS-1:0]    out_flat;
  logic [CHANNELS-1:0]       ch_wr;
  logic [15:0] aoff, rword;
  logic [7:0]  dout_q, dout_d;
  logic        hit, rd_edge, wr_edge, rd_prev_q, wr_prev_q, irq_q;

  // 16-bit wraparound subtract makes addresses below BASE_ADDR miss too
  assign aoff    = bus.Address - BASE_ADDR;
  assign hit     = aoff < 16'(8*CHANNELS);
  assign rd_edge = bus.ReadRedbus & ~rd_prev_q;
  assign wr_edge = bus.WriteRedbus & bus.Enable & ~wr_prev_q;

  always_comb begin
    rword = '0;
    ch_wr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (aoff[6:3] == 4'(c)) begin
        ch_wr[c] = wr_edge & hit;
        case (aoff[2:1])
          2'd0:    rword = in_w[c];
`ifdef IOEXP_OUTPUT_READBACK_EN
          2'd1:    rword = out_w[c];
`else
          2'd1:    rword = '0;
`endif
          2'd2:    rword = chg_w[c];
          default: rword = mask_w[c];
        endcase
      end
    end
    dout_d = dout_q;
    if (rd_edge & bus.Enable & hit)
      dout_d = aoff[0] ? rword[15:8] : rword[7:0];
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      redbus_io_expander_multi_chan #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .wr_i    (ch_wr[g]),
        .off_i   (aoff[2:0]),
        .wdata_i (Data),
        .pin_i   (IOPort[16*g +: 16]),
        .in_o    (in_w[g]),
        .out_o   (out_w[g]),
        .chg_o   (chg_w[g]),
        .mask_o  (mask_w[g])
      );
    end
    assign out_flat = out_w;
    for (g = 0; g < 16*CHANNELS; g++) begin : g_pin
      assign IOPort[g] = out_flat[g] ? 1'b1 : 1'bz;
    end
  endgenerate

  // prev flags reset high so a strobe held across reset release is not an edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      dout_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_prev_q <= bus.ReadRedbus;
      wr_prev_q <= bus.WriteRedbus;
      dout_q    <= dout_d;
      irq_q     <= |(chg_w & mask_w);
    end
  end

  assign Data = (bus.Enable & bus.ReadRedbus & hit) ? dout_q : 8'bz;
  assign Irq  = irq_q;
endmodule
